rob_retire: RTL and testbench

//  In-order commit stage directly downstream of the reorder buffer. Examines the ROB head entry

---
 rtl/rob_retire.sv | 100 ++++++++++
 tb/tb_rob_retire.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rob_retire.sv
// rob_retire: in-order ROB commit stage with RF write, tag clear and store req/ack (optional RETIRE_PERF_CNT_EN counter)
module rob_retire #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              head_valid,
  input  logic              head_ready,
  input  logic [TAG_W-1:0]  head_tag,
  input  logic [4:0]        head_rd,
  input  logic [1:0]        head_type,
  input  logic [DATA_W-1:0] head_data,
  input  logic [DATA_W-1:0] head_st_addr,
  input  logic [DATA_W-1:0] head_pc,
  output logic              retire_pop,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rst_clr_en,
  output logic [TAG_W-1:0]  rst_clr_tag,
  output logic              st_req,
  output logic [DATA_W-1:0] st_addr,
  output logic [DATA_W-1:0] st_data,
  input  logic              st_ack,
`ifdef RETIRE_PERF_CNT_EN
  output logic [31:0]       retired_cnt,
`endif
  output logic [DATA_W-1:0] retire_pc
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              wen_q;
  logic [4:0]        waddr_q;
  logic [DATA_W-1:0] wdata_q, st_addr_q, st_data_q, pc_q;
  logic [TAG_W-1:0]  tag_q;
  logic              head_go, is_store, wr_c, st_take;

  assign head_go  = head_valid & head_ready;
  assign is_store = head_type == 2'b10;
  // In ST_WAIT the head is the pending store, so the ack alone retires it.
  assign retire_pop = ~i_rst & (state_q == ST_WAIT ? st_ack : head_go & ~is_store);
  // INT/LOAD only (type bit1 clear); x0 is never written nor tagged.
  assign wr_c    = (state_q == IDLE) & retire_pop & ~head_type[1] & (|head_rd);
  assign st_take = (state_q == IDLE) & head_go & is_store;

  // Next-state: enter ST_WAIT on a ready store, leave on ack
  always_comb begin
    state_d = state_q == IDLE ? (st_take ? ST_WAIT : IDLE) : (st_ack ? IDLE : ST_WAIT);
  end

  // Retirement registers: RF/tag pulse, store latch, last retired PC
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      tag_q     <= '0;
      st_addr_q <= '0;
      st_data_q <= '0;
      pc_q      <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wr_c;
      if (wr_c) begin
        waddr_q <= head_rd;
        wdata_q <= head_data;
        tag_q   <= head_tag;
      end
      if (st_take) begin
        st_addr_q <= head_st_addr;
        st_data_q <= head_data;
      end
      if (retire_pop) pc_q <= head_pc;
    end
  end

`ifdef RETIRE_PERF_CNT_EN
  logic [31:0] cnt_q;
  // Count retirements; wraps naturally
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_q + {31'd0, retire_pop};
  end
  assign retired_cnt = cnt_q;
`endif

  assign rf_wen      = wen_q;
  assign rst_clr_en  = wen_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign rst_clr_tag = tag_q;
  assign st_req      = state_q == ST_WAIT;
  assign st_addr     = st_addr_q;
  assign st_data     = st_data_q;
  assign retire_pc   = pc_q;
endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire: directed and random checks of rob_retire against a behavioural model
module tb_rob_retire;
  logic        clk = 1'b0, rst = 1'b1;
  logic        hv = 0, hr = 0, ack = 0;
  logic [4:0]  htag = 0, hrd = 0;
  logic [1:0]  htype = 0;
  logic [31:0] hdata = 0, haddr = 0, hpc = 0;
  logic        pop, wen, clr_en, sreq;
  logic [4:0]  waddr, ctag;
  logic [31:0] wdata, saddr, sdata, rpc;
`ifdef RETIRE_PERF_CNT_EN
  logic [31:0] cnt;
`endif
  int checks = 0, errors = 0;
  bit model_ok = 0;

  // model: store_pending marks an accepted store awaiting memory; m_* are what the outputs must show
  bit          store_pending;
  bit          m_wen, m_sreq;
  logic [4:0]  m_waddr, m_tag;
  logic [31:0] m_wdata, m_saddr, m_sdata, m_pc, m_cnt;

  rob_retire dut (
    .i_clk(clk), .i_rst(rst), .head_valid(hv), .head_ready(hr), .head_tag(htag),
    .head_rd(hrd), .head_type(htype), .head_data(hdata), .head_st_addr(haddr),
    .head_pc(hpc), .retire_pop(pop), .rf_wen(wen), .rf_waddr(waddr), .rf_wdata(wdata),
    .rst_clr_en(clr_en), .rst_clr_tag(ctag), .st_req(sreq), .st_addr(saddr),
    .st_data(sdata), .st_ack(ack),
`ifdef RETIRE_PERF_CNT_EN
    .retired_cnt(cnt),
`endif
    .retire_pc(rpc));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_pop();
    if (rst) return 0;
    if (store_pending) return ack;
    return hv && hr && htype != 2'b10;
  endfunction

  task automatic compare();
    if (!model_ok) return;
    chk("retire_pop", {31'd0, pop}, {31'd0, exp_pop()});
    chk("rf_wen", {31'd0, wen}, {31'd0, m_wen});
    chk("rst_clr_en", {31'd0, clr_en}, {31'd0, m_wen});
    chk("rf_waddr", {27'd0, waddr}, {27'd0, m_waddr});
    chk("rf_wdata", wdata, m_wdata);
    chk("rst_clr_tag", {27'd0, ctag}, {27'd0, m_tag});
    chk("st_req", {31'd0, sreq}, {31'd0, m_sreq});
    chk("st_addr", saddr, m_saddr);
    chk("st_data", sdata, m_sdata);
    chk("retire_pc", rpc, m_pc);
`ifdef RETIRE_PERF_CNT_EN
    chk("retired_cnt", cnt, m_cnt);
`endif
  endtask

  task automatic model_edge();
    bit p, w;
    p = exp_pop();
    if (rst) begin
      store_pending = 0; m_wen = 0; m_sreq = 0; m_waddr = 0; m_wdata = 0; m_tag = 0;
      m_saddr = 0; m_sdata = 0; m_pc = 0; m_cnt = 0;
      model_ok = 1;
      return;
    end
    w = p && !store_pending && (htype == 2'b00 || htype == 2'b01) && hrd != 0;
    m_wen = w;
    if (w) begin m_waddr = hrd; m_wdata = hdata; m_tag = htag; end
    if (p) begin m_pc = hpc; m_cnt = m_cnt + 1; end
    if (store_pending) begin
      if (ack) begin store_pending = 0; m_sreq = 0; end
    end else if (hv && hr && htype == 2'b10) begin
      store_pending = 1; m_sreq = 1; m_saddr = haddr; m_sdata = hdata;
    end
  endtask

  // one clock: compare mid-cycle, update model at the edge, return just after it
  task automatic cycle();
    #3 compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_head(input bit v, input bit r, input logic [4:0] t, input logic [4:0] rd,
                          input logic [1:0] ty, input logic [31:0] d, input logic [31:0] a,
                          input logic [31:0] pc);
    hv = v; hr = r; htag = t; hrd = rd; htype = ty; hdata = d; haddr = a; hpc = pc;
  endtask

  task automatic new_random_head();
    set_head($urandom_range(3) != 0, $urandom_range(1), 5'($urandom), 5'($urandom_range(3) == 0 ? 0 : $urandom),
             2'($urandom), $urandom, $urandom, $urandom);
  endtask

  initial begin
    // 1: reset with a ready head present
    set_head(1, 1, 5'd3, 5'd4, 2'b00, 32'h1234, 0, 32'h40);
    rst = 1;
    #1 chk("pop in reset", {31'd0, pop}, 0);
    cycle(); cycle();
    chk("reset rf_wen", {31'd0, wen}, 0);
    chk("reset st_req", {31'd0, sreq}, 0);
    chk("reset retire_pc", rpc, 0);
    rst = 0;
    // 2: single INT retire
    set_head(1, 1, 5'd7, 5'd5, 2'b00, 32'hDEAD_BEEF, 0, 32'h100);
    #1 chk("int pop", {31'd0, pop}, 1);
    cycle();
    chk("int rf_wen", {31'd0, wen}, 1);
    chk("int waddr", {27'd0, waddr}, 5);
    chk("int wdata", wdata, 32'hDEAD_BEEF);
    chk("int clr_tag", {27'd0, ctag}, 7);
    // 3: three back-to-back, then not-ready head
    for (int i = 0; i < 3; i++) begin
      set_head(1, 1, 5'(8 + i), 5'(10 + i), 2'b01, 32'(i + 100), 0, 32'(32'h200 + 4 * i));
      cycle();
      chk("b2b waddr", {27'd0, waddr}, 32'(10 + i));
    end
    set_head(1, 0, 5'd11, 5'd13, 2'b00, 32'h77, 0, 32'h20C);
    #1 chk("not ready pop", {31'd0, pop}, 0);
    cycle();
    chk("not ready wen", {31'd0, wen}, 0);
    hr = 1; cycle();
    chk("ready later wdata", wdata, 32'h77);
    // 4: store with ack after three cycles
    set_head(1, 1, 5'd12, 5'd0, 2'b10, 32'h55, 32'h100, 32'h300);
    #1 chk("store no pop", {31'd0, pop}, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      ack = (i == 2);
      #1 chk("store pop only on ack", {31'd0, pop}, {31'd0, ack});
      cycle();
      if (i < 2) begin
        chk("st_req held", {31'd0, sreq}, 1);
        chk("st_addr held", saddr, 32'h100);
        chk("st_data held", sdata, 32'h55);
      end
      chk("store no rf_wen", {31'd0, wen}, 0);
    end
    ack = 0;
    chk("st_req dropped", {31'd0, sreq}, 0);
    chk("store retire_pc", rpc, 32'h300);
    // 5: x0 INT and BRANCH
    set_head(1, 1, 5'd1, 5'd0, 2'b00, 32'h9, 0, 32'h400);
    cycle();
    chk("x0 wen", {31'd0, wen}, 0);
    chk("x0 pc", rpc, 32'h400);
    set_head(1, 1, 5'd2, 5'd6, 2'b11, 32'h9, 0, 32'h404);
    cycle();
    chk("branch clr", {31'd0, clr_en}, 0);
    chk("branch pc", rpc, 32'h404);
    // 6: reset during ST_WAIT
    set_head(1, 1, 5'd3, 5'd0, 2'b10, 32'hAA, 32'h500, 32'h408);
    cycle();
    chk("st_req before reset", {31'd0, sreq}, 1);
    rst = 1; ack = 1;
    #1 chk("reset wait no pop", {31'd0, pop}, 0);
    cycle();
    chk("reset wait st_req", {31'd0, sreq}, 0);
    rst = 0; ack = 0;
    // random ROB-like traffic: head changes only after it retires
    new_random_head();
    for (int n = 0; n < 3000; n++) begin
      bit popped;
      ack = store_pending && $urandom_range(3) == 0;
      if (n % 997 == 996) rst = 1;
      popped = exp_pop();
      cycle();
      rst = 0;
      if (popped || !hv) new_random_head();
      else if (!hr) hr = $urandom_range(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
